// File: rtl/mm_iddmm_pkg.sv
// mm_iddmm_pkg: shared state encoding and width/length helpers for the Montgomery controller
package mm_iddmm_pkg;
  typedef enum logic [2:0] {IDLE, ROW, CARRY, SUB, COPY, FIN} state_t;
  function automatic int row_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int row_cyc(input int n);
    return n + 2;
  endfunction
endpackage

// File: rtl/mm_word_sub.sv
// mm_word_sub: K-bit word subtractor with registered borrow (clr zeroes it, en advances it)
// Ports: a, b operand words; diff = a - b - borrow; bout = borrow out of this word.
module mm_word_sub #(
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] diff,
  output logic         bout
);
  logic borrow;
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, borrow};
  always_ff @(posedge clk)
    if (rst || clr) borrow <= 1'b0;
    else if (en) borrow <= bout;
endmodule

// File: rtl/mm_iddmm_ctrl.sv
// mm_iddmm_ctrl: sequencer for the word-serial Montgomery PE plus final conditional subtraction
// Ports: start/busy/done handshake; pe_i/pe_j/pe_j00 drive the PE, pe_carry/pe_uj come back;
// a_* is the A scratch memory (write port + combinational read), m_* the modulus read port,
// r_* the result memory write port; final_sel=1 means the result is A unchanged.
// Optional MM_IDDMM_CTRL_PERF_EN adds cyc_cnt (operation cycle count) and sub_skipped.
module mm_iddmm_ctrl import mm_iddmm_pkg::*; #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int IW = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] pe_i,
  output logic [$clog2(N):0]   pe_j,
  output logic                 pe_j00,
  input  logic                 pe_carry,
  input  logic [K-1:0]         pe_uj,
  output logic                 a_we,
  output logic [IW-1:0]        a_waddr,
  output logic [K-1:0]         a_wdata,
  output logic [IW-1:0]        a_raddr,
  input  logic [K-1:0]         a_rdata,
  output logic [IW-1:0]        m_raddr,
  input  logic [K-1:0]         m_rdata,
  output logic                 r_we,
  output logic [$clog2(N)-1:0] r_waddr,
  output logic [K-1:0]         r_wdata,
`ifdef MM_IDDMM_CTRL_PERF_EN
  output logic [31:0]          cyc_cnt,
  output logic                 sub_skipped,
`endif
  output logic                 final_sel
);
  localparam int IIW = row_w(N);
  localparam int JW = idx_w(N);
  localparam int ROW_LAST = row_cyc(N) - 1;
  state_t state, state_n;
  // cnt is the row phase p in ROW and the word index s in SUB/COPY
  logic [JW-1:0] cnt, cnt_n;
  logic [IIW-1:0] i, i_n;
  logic fsel_n, acc, bout;
  logic [K-1:0] diff;
  assign acc = state == IDLE && start;
  assign busy = state inside {ROW, CARRY, SUB, COPY};
  assign done = state == FIN;
  assign pe_j00 = state == ROW && cnt == '0;
  assign pe_i = (state == ROW || state == CARRY) ? i : '0;
  // CARRY keeps the last column index of the final row
  assign pe_j = state == ROW ? (cnt < JW'(2) ? '0 : cnt - 1'b1) : state == CARRY ? JW'(N) : '0;
  assign a_raddr = state == ROW ? IW'(pe_j) : (state == SUB || state == COPY) ? IW'(cnt) : '0;
  assign m_raddr = state == ROW ? IW'(pe_j) : state == SUB ? IW'(cnt) : '0;
  assign a_we = (state == ROW && pe_j != '0) || state == CARRY;
  assign a_waddr = (state == ROW && a_we) ? IW'(pe_j - 1'b1) : state == CARRY ? IW'(N) : '0;
  assign a_wdata = (state == ROW && a_we) ? pe_uj : state == CARRY ? {{(K-1){1'b0}}, pe_carry} : '0;
  // word N of the subtraction only feeds the borrow, it is never stored
  assign r_we = (state == SUB && cnt != JW'(N)) || state == COPY;
  assign r_waddr = r_we ? cnt[IIW-1:0] : '0;
  assign r_wdata = (state == SUB && r_we) ? diff : state == COPY ? a_rdata : '0;
  mm_word_sub #(.K(K)) u_sub (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc),
    .en   (state == SUB),
    .a    (a_rdata),
    .b    (m_rdata),
    .diff (diff),
    .bout (bout)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    i_n = i;
    fsel_n = final_sel;
    case (state)
      IDLE: if (start) begin
        state_n = ROW;
        cnt_n = '0;
        i_n = '0;
        fsel_n = 1'b0;
      end
      ROW: begin
        cnt_n = cnt == JW'(ROW_LAST) ? '0 : cnt + 1'b1;
        if (cnt == JW'(ROW_LAST)) begin
          state_n = i == IIW'(N - 1) ? CARRY : ROW;
          i_n = i == IIW'(N - 1) ? i : i + 1'b1;
        end
      end
      CARRY: begin
        state_n = SUB;
        cnt_n = '0;
      end
      SUB: begin
        cnt_n = cnt == JW'(N) ? '0 : cnt + 1'b1;
        // a final borrow means A < m, so A itself is the result
        if (cnt == JW'(N)) state_n = bout ? COPY : FIN;
      end
      COPY: begin
        cnt_n = cnt + 1'b1;
        if (cnt == JW'(N - 1)) begin
          state_n = FIN;
          fsel_n = 1'b1;
        end
      end
      FIN: begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      i <= '0;
      final_sel <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      i <= i_n;
      final_sel <= fsel_n;
    end
`ifdef MM_IDDMM_CTRL_PERF_EN
  always_ff @(posedge clk)
    if (rst || acc) begin
      cyc_cnt <= '0;
      sub_skipped <= 1'b0;
    end else begin
      if (state != IDLE && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (state == SUB && cnt == JW'(N)) sub_skipped <= !bout;
    end
`endif
endmodule

// File: tb/tb_mm_iddmm_ctrl.sv
// tb_mm_iddmm_ctrl: randomized scoreboard bench for mm_iddmm_ctrl with an emulated PE and memories
module tb_mm_iddmm_ctrl;
  localparam int K = 16;
  localparam int N = 4;
  localparam int IW = 3;
  localparam int W = K * (N + 1);
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, pe_j00, pe_carry, a_we, r_we, final_sel;
  logic [1:0] pe_i, r_waddr;
  logic [2:0] pe_j;
  logic [K-1:0] pe_uj, a_wdata, a_rdata, m_rdata, r_wdata;
  logic [IW-1:0] a_waddr, a_raddr, m_raddr;
`ifdef MM_IDDMM_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic sub_skipped;
`endif
  logic [K-1:0] uj_tab [N][N+1];
  logic [K-1:0] amem [8];
  logic [K-1:0] mmem [8];
  logic [K-1:0] rmem [N];
  logic carry_v = 0;
  logic [IW+K-1:0] aq [$];
  logic [IW+K-1:0] rq [$];
  int dq [$];
  int total = 0, bad = 0, cyc = 0, t0 = 0;

  mm_iddmm_ctrl #(.K(K), .N(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pe_i(pe_i), .pe_j(pe_j), .pe_j00(pe_j00), .pe_carry(pe_carry), .pe_uj(pe_uj),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_raddr(a_raddr), .a_rdata(a_rdata),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .r_we(r_we), .r_waddr(r_waddr), .r_wdata(r_wdata),
`ifdef MM_IDDMM_CTRL_PERF_EN
    .cyc_cnt(cyc_cnt), .sub_skipped(sub_skipped),
`endif
    .final_sel(final_sel)
  );

  always #5 clk = ~clk;
  assign pe_uj = uj_tab[pe_i][pe_j];
  assign pe_carry = carry_v;
  assign a_rdata = amem[a_raddr];
  assign m_rdata = m_raddr < IW'(N) ? mmem[m_raddr] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_we) amem[a_waddr] <= a_wdata;
    if (r_we) rmem[r_waddr] <= r_wdata;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [IW+K-1:0] e;
    int d;
    if (!rst) begin
      if (a_we) begin
        e = aq.size() > 0 ? aq.pop_front() : '1;
        check("a_write", {a_waddr, a_wdata}, e);
      end
      if (r_we) begin
        e = rq.size() > 0 ? rq.pop_front() : '1;
        check("r_write", {IW'(r_waddr), r_wdata}, e);
      end
      if (done) begin
        d = dq.size() > 0 ? dq.pop_front() : -1;
        check("done_sel_lat", final_sel * 1000 + (cyc - t0 + 1), d);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic chk_zero(input string nm);
    check(nm, {busy, done, pe_i, pe_j, pe_j00, a_we, a_waddr, a_wdata, a_raddr, m_raddr,
               r_we, r_waddr, r_wdata, final_sel}, 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c <= N; c++) uj_tab[r][c] = K'($urandom);
    for (int s = 0; s < 8; s++) mmem[s] = s < N ? K'($urandom) : '0;
    mmem[0][0] = 1'b1;
  endtask

  task automatic push_awrites();
    for (int r = 0; r < N; r++)
      for (int c = 1; c <= N; c++) aq.push_back({IW'(c - 1), uj_tab[r][c]});
    aq.push_back({IW'(N), K'(carry_v)});
  endtask

  // mode 0 random A, 1 A=m, 2 A=m-1, 3 A<m, 4 A>m with carry word set
  task automatic run(input int mode, input bit poke);
    logic [W-1:0] mb, ab, diffb, res;
    logic lt;
    int lat;
    fill_random();
    if (mode == 3) mmem[N-1] = 16'hFFFF;
    mb = '0;
    for (int s = 0; s < N; s++) mb[K*s +: K] = mmem[s];
    ab = '0;
    for (int s = 0; s < N; s++) ab[K*s +: K] = K'($urandom);
    ab[K*N] = 1'($urandom);
    if (mode == 1) ab = mb;
    if (mode == 2) ab = mb - 1;
    if (mode == 3) begin ab[K*N] = 1'b0; ab[K*(N-1) +: K] = ab[K*(N-1) +: K] & 16'h7FFF; end
    if (mode == 4) ab[K*N] = 1'b1;
    for (int c = 1; c <= N; c++) uj_tab[N-1][c] = ab[K*(c-1) +: K];
    carry_v = ab[K*N];
    lt = ab < mb;
    diffb = ab - mb;
    res = lt ? ab : diffb;
    lat = N * (N + 2) + 1 + (N + 1) + 1 + (lt ? N : 0);
    push_awrites();
    for (int s = 0; s < N; s++) rq.push_back({IW'(s), diffb[K*s +: K]});
    if (lt) for (int s = 0; s < N; s++) rq.push_back({IW'(s), ab[K*s +: K]});
    dq.push_back(lt * 1000 + lat);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    t0 = cyc;
    check("busy_after_start", busy, 1);
    if (poke) begin
      repeat (5) @(negedge clk);
      start = 1;
      @(negedge clk) start = 0;
    end
    for (int n = 0; n < 200 && !done; n++) @(negedge clk);
    check("done_seen", done, 1);
    repeat (2) @(negedge clk);
    check("aq_drained", aq.size(), 0);
    check("rq_drained", rq.size(), 0);
    check("dq_drained", dq.size(), 0);
    for (int s = 0; s < N; s++) check("result_word", rmem[s], res[K*s +: K]);
    check("final_sel_hold", {busy, done, final_sel}, {2'b00, lt});
`ifdef MM_IDDMM_CTRL_PERF_EN
    check("cyc_cnt", cyc_cnt, lat);
    check("sub_skipped", sub_skipped, !lt);
`endif
    aq.delete(); rq.delete(); dq.delete();
  endtask

  task automatic abort_run();
    int n;
    fill_random();
    carry_v = 1'b0;
    push_awrites();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (n = 0; n < 200 && !(pe_i == 2 && pe_j == 2); n++) @(negedge clk);
    check("reach_row2_p3", {pe_i, pe_j}, {2'd2, 3'd2});
    #1 rst = 1;
    @(negedge clk);
    chk_zero("zero_after_abort");
    rst = 0;
    aq.delete(); rq.delete(); dq.delete();
    repeat (N) @(negedge clk);
    check("no_done_after_abort", {busy, done}, 0);
  endtask

  initial begin
    for (int s = 0; s < 8; s++) amem[s] = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c <= N; c++) uj_tab[r][c] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 0;
    run(0, 0);
    run(1, 0);
    run(2, 0);
    run(3, 0);
    run(4, 1);
    run(0, 1);
    abort_run();
    run(0, 0);
    run(2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
